// File: rtl/sram_axi_burst_bridge_if.sv
// rtl/sram_axi_burst_bridge_if.sv - AXI3/4 master-side channel bundle for the burst bridge
interface sram_axi_burst_bridge_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_burst_bridge.sv
// rtl/sram_axi_burst_bridge.sv - inst/data SRAM-like ports to one AXI burst master; BRIDGE_RESP_ERR_EN enables data_err
module sram_axi_burst_bridge #(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  inst_req,
    input  logic [31:0]           inst_addr,
    input  logic [LEN_W-1:0]      inst_len,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic                  inst_last,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [2:0]            data_size,
    input  logic [31:0]           data_addr,
    input  logic [LEN_W-1:0]      data_len,
    output logic                  data_addr_ok,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic                  data_wvalid,
    output logic                  data_wready,
    output logic                  data_data_ok,
    output logic                  data_last,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_err,

    sram_axi_burst_bridge_if.master axi
);
    localparam int          CNT_W     = $clog2(MAX_LEN) + 1;
    localparam logic [2:0]  INST_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP
    } state_t;

    state_t            state;
    logic [31:0]       lat_addr;
    logic [LEN_W-1:0]  lat_len;
    logic [2:0]        lat_size;
    logic [ID_W-1:0]   lat_id;
    logic              lat_is_data;
    logic              arvalid_q;
    logic              awvalid_q;
    logic              rready_q;
    logic              bready_q;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_done;
    logic              aw_done;

    logic              idle;
    logic              rd_beat;
    logic              wr_resp_beat;
    logic              w_phase;
    logic              w_fire;
    logic              aw_fire;
    logic              w_last_beat;

    assign idle         = resetn && (state == IDLE);
    assign rd_beat      = resetn && rready_q && axi.rvalid;
    assign wr_resp_beat = resetn && bready_q && axi.bvalid;
    // W beats are only offered while the burst is still short of its last beat
    assign w_phase      = (state == WR_ADDR) && !w_done;
    assign w_last_beat  = (w_cnt == CNT_W'(lat_len));
    assign w_fire       = w_phase && data_wvalid && axi.wready;
    assign aw_fire      = awvalid_q && axi.awready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_len     <= '0;
            lat_size    <= '0;
            lat_id      <= '0;
            lat_is_data <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            w_cnt       <= '0;
            w_done      <= 1'b0;
            aw_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        lat_addr    <= data_addr;
                        lat_len     <= data_len;
                        lat_size    <= data_size;
                        lat_id      <= ID_W'(DATA_ID);
                        lat_is_data <= 1'b1;
                        w_cnt       <= '0;
                        w_done      <= 1'b0;
                        aw_done     <= 1'b0;
                        if (data_wr) begin
                            state     <= WR_ADDR;
                            awvalid_q <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (inst_req) begin
                        lat_addr    <= inst_addr;
                        lat_len     <= inst_len;
                        lat_size    <= INST_SIZE;
                        lat_id      <= ID_W'(INST_ID);
                        lat_is_data <= 1'b0;
                        state       <= RD_ADDR;
                        arvalid_q   <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // rlast is trusted; a single outstanding burst needs no beat count
                    if (axi.rvalid && axi.rlast) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR_ADDR: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        w_cnt <= w_cnt + 1'b1;
                        if (w_last_beat) begin
                            w_done <= 1'b1;
                        end
                    end
                    if ((aw_done || aw_fire) && (w_done || (w_fire && w_last_beat))) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_addr_ok = idle;
    assign inst_addr_ok = idle && !data_req;

    assign inst_data_ok = rd_beat && !lat_is_data;
    assign inst_last    = inst_data_ok && axi.rlast;
    assign inst_rdata   = axi.rdata;

    assign data_data_ok = (rd_beat && lat_is_data) || wr_resp_beat;
    assign data_last    = (rd_beat && lat_is_data && axi.rlast) || wr_resp_beat;
    assign data_rdata   = axi.rdata;
    assign data_wready  = w_phase && axi.wready;

`ifdef BRIDGE_RESP_ERR_EN
    // Instruction-side errors share data_err, qualified by inst_data_ok
    assign data_err = (rd_beat && axi.rresp[1]) || (wr_resp_beat && axi.bresp[1]);
`else
    assign data_err = 1'b0;
`endif

    assign axi.arid    = lat_id;
    assign axi.araddr  = lat_addr;
    assign axi.arlen   = 8'(lat_len);
    assign axi.arsize  = lat_size;
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = lat_id;
    assign axi.awaddr  = lat_addr;
    assign axi.awlen   = 8'(lat_len);
    assign axi.awsize  = lat_size;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_q;

    assign axi.wid     = lat_id;
    assign axi.wdata   = data_wdata;
    assign axi.wstrb   = data_wstrb;
    assign axi.wlast   = w_last_beat;
    assign axi.wvalid  = w_phase && data_wvalid;
    assign axi.bready  = bready_q;

    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.bid, axi.rresp, axi.bresp};
endmodule

// File: tb/tb_sram_axi_burst_bridge.sv
// tb/tb_sram_axi_burst_bridge.sv - directed self-checking bench for sram_axi_burst_bridge
module tb_sram_axi_burst_bridge;
`ifdef BRIDGE_RESP_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [3:0]  inst_len;
    logic        inst_addr_ok, inst_data_ok, inst_last;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [2:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_len;
    logic        data_addr_ok;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_wvalid, data_wready;
    logic        data_data_ok, data_last;
    logic [31:0] data_rdata;
    logic        data_err;

    int checks   = 0;
    int failures = 0;

    sram_axi_burst_bridge_if #(.ID_W(4), .DATA_W(32)) axi ();

    sram_axi_burst_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_len(inst_len),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_last(inst_last), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_len(data_len), .data_addr_ok(data_addr_ok),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_wvalid(data_wvalid), .data_wready(data_wready),
        .data_data_ok(data_data_ok), .data_last(data_last),
        .data_rdata(data_rdata), .data_err(data_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [3:0] len,
                             input int aw_delay, input bit toggle, input logic [1:0] bresp_v);
        int k = 0;
        int i = 0;
        int hs = 0;
        int lastc = 0;
        bit awd = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = addr; data_len = len;
        data_size = 3'd2; data_wstrb = 4'hF;
        #1;
        chk("wr_accept", data_addr_ok, 1);
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        while (!((k == int'(len) + 1) && awd) && i < 40) begin
            axi.wready  = toggle ? (i % 2 == 0) : 1'b1;
            axi.awready = (i >= aw_delay) && !awd;
            data_wvalid = 1'b1;
            data_wdata  = 32'hA000_0000 | 32'(k);
            #1;
            chk("awvalid", axi.awvalid, !awd);
            if (!awd) chk("awaddr_stable", axi.awaddr, addr);
            chk("wvalid", axi.wvalid, k <= int'(len));
            chk("data_wready", data_wready, axi.wready && (k <= int'(len)));
            if (k <= int'(len)) begin
                chk("wdata", axi.wdata, 32'hA000_0000 | 32'(k));
                chk("wlast", axi.wlast, k == int'(len));
            end
            if (axi.wvalid && axi.wready) begin
                hs++;
                if (axi.wlast) lastc++;
            end
            tick();
            if (axi.wready && k <= int'(len)) k++;
            if (axi.awready) awd = 1'b1;
            i++;
        end
        chk("wr_timeout", i < 40, 1);
        chk("w_beats", hs, int'(len) + 1);
        chk("wlast_count", lastc, 1);
        axi.wready = 1'b0; axi.awready = 1'b0; data_wvalid = 1'b0;
        #1;
        chk("bready", axi.bready, 1);
        chk("aw_after", axi.awvalid, 0);
        chk("w_after", axi.wvalid, 0);
        chk("no_early_ok", data_data_ok, 0);
        tick();
        axi.bvalid = 1'b1; axi.bresp = bresp_v;
        #1;
        chk("b_data_ok", data_data_ok, 1);
        chk("b_last", data_last, 1);
        chk("b_err", data_err, bresp_v[1] & ERR_ON);
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        #1;
        chk("b_idle_bready", axi.bready, 0);
        chk("b_idle_ok", data_addr_ok, 1);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_addr = 0; inst_len = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_len = 0;
        data_wdata = 0; data_wstrb = 0; data_wvalid = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
        tick(); tick();
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_err", data_err, 0);
        resetn = 1'b1;
        #1;
        chk("idle_data_addr_ok", data_addr_ok, 1);
        chk("idle_inst_addr_ok", inst_addr_ok, 1);

        // Instruction burst, 4 beats, error response on beat 0
        inst_req = 1; inst_addr = 32'h1FC0_0000; inst_len = 4'd3;
        #1;
        chk("i_accept", inst_addr_ok, 1);
        tick();
        inst_req = 0;
        #1;
        chk("i_arvalid", axi.arvalid, 1);
        chk("i_araddr", axi.araddr, 32'h1FC0_0000);
        chk("i_arlen", axi.arlen, 8'd3);
        chk("i_arid", axi.arid, 4'd0);
        chk("i_arsize", axi.arsize, 3'd2);
        chk("i_arburst", axi.arburst, 2'b01);
        chk("i_busy_ok", data_addr_ok, 0);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        for (int b = 0; b < 4; b++) begin
            axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hC0DE_0000 + 32'(b);
            axi.rlast = (b == 3); axi.rresp = (b == 0) ? 2'b10 : 2'b00;
            #1;
            chk("i_data_ok", inst_data_ok, 1);
            chk("i_rdata", inst_rdata, 32'hC0DE_0000 + 32'(b));
            chk("i_last", inst_last, b == 3);
            chk("i_not_data", data_data_ok, 0);
            chk("i_err", data_err, (b == 0) ? ERR_ON : 1'b0);
            tick();
        end
        axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
        #1;
        chk("i_back_idle", data_addr_ok, 1);
        chk("i_rready_off", axi.rready, 0);

        // Simultaneous requests: data wins, inst waits
        inst_req = 1; inst_addr = 32'h1FC0_0040; inst_len = 4'd0;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_0010; data_len = 4'd0; data_size = 3'd2;
        #1;
        chk("arb_data_ok", data_addr_ok, 1);
        chk("arb_inst_blocked", inst_addr_ok, 0);
        tick();
        data_req = 0;
        #1;
        chk("d_araddr", axi.araddr, 32'h8000_0010);
        chk("d_arid", axi.arid, 4'd1);
        chk("d_arlen", axi.arlen, 8'd0);
        chk("d_inst_wait", inst_addr_ok, 0);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        axi.rvalid = 1; axi.rlast = 1; axi.rid = 1; axi.rdata = 32'h5555_AAAA;
        #1;
        chk("d_data_ok", data_data_ok, 1);
        chk("d_last", data_last, 1);
        chk("d_rdata", data_rdata, 32'h5555_AAAA);
        chk("d_no_inst_ok", inst_data_ok, 0);
        chk("d_no_accept_on_done", inst_addr_ok, 0);
        tick();
        axi.rvalid = 0; axi.rlast = 0;
        #1;
        chk("arb_inst_now", inst_addr_ok, 1);
        tick();
        inst_req = 0;
        #1;
        chk("arb_i_araddr", axi.araddr, 32'h1FC0_0040);
        chk("arb_i_arid", axi.arid, 4'd0);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        axi.rvalid = 1; axi.rlast = 1; axi.rid = 0; axi.rdata = 32'h1234_5678;
        #1;
        chk("arb_i_data_ok", inst_data_ok, 1);
        chk("arb_i_last", inst_last, 1);
        tick();
        axi.rvalid = 0; axi.rlast = 0;

        // Writes: long toggled burst, W-before-AW, same-cycle completion
        run_write(32'h8000_1000, 4'd7, 5, 1'b1, 2'b00);
        run_write(32'h8000_2000, 4'd1, 4, 1'b0, 2'b00);
        run_write(32'h8000_3000, 4'd0, 0, 1'b0, 2'b10);

        // Reset during beat 2 of a 4-beat data read
        data_req = 1; data_wr = 0; data_addr = 32'h8000_4000; data_len = 4'd3;
        tick();
        data_req = 0;
        axi.arready = 1;
        tick();
        axi.arready = 0;
        axi.rvalid = 1; axi.rlast = 0; axi.rid = 1; axi.rdata = 32'hBEEF_0000;
        #1;
        chk("rst_beat1", data_data_ok, 1);
        tick();
        resetn = 0;
        axi.rdata = 32'hBEEF_0001;
        #1;
        chk("rst_beat2_gated", data_data_ok, 0);
        tick();
        axi.rvalid = 0;
        #1;
        chk("mid_rst_rready", axi.rready, 0);
        chk("mid_rst_arvalid", axi.arvalid, 0);
        chk("mid_rst_awvalid", axi.awvalid, 0);
        chk("mid_rst_wvalid", axi.wvalid, 0);
        chk("mid_rst_bready", axi.bready, 0);
        resetn = 1;
        #1;
        chk("post_rst_addr_ok", data_addr_ok, 1);
        chk("post_rst_rready", axi.rready, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
